// File: rtl/des_sbox_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_sbox_scheduler_if
//  Description : Handshake bundle for des_sbox_scheduler. Carries the two
//                requester channels (valid/data/ready) and the result channel
//                (valid/data/id/ready).
//  Ports       : in0_valid/in0_data/in0_ready  requester 0 job channel
//                in1_valid/in1_data/in1_ready  requester 1 job channel
//                out_valid/out_data/out_id/out_ready  result channel
//  Revision    : 1.0  initial release
// ============================================================================
interface des_sbox_scheduler_if;
  logic        in0_valid;
  logic [47:0] in0_data;
  logic        in0_ready;
  logic        in1_valid;
  logic [47:0] in1_data;
  logic        in1_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_id;
  logic        out_ready;

  // Requesters and result consumer (testbench / surrounding logic)
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_id
  );

  // The scheduler itself
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_id
  );
endinterface
`default_nettype wire

// File: rtl/des_sbox_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : des_sbox_scheduler
//  Description : Shares one bank of DES S-box lookups between two requesters.
//                A round-robin arbiter accepts a 48-bit round-function input,
//                the eight 6-bit groups are substituted LANES at a time over
//                8/LANES cycles, and the 32-bit result is held until taken.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    des_sbox_scheduler_if.slave (requester + result
//                       channels, see interface file)
//  Parameters  : LANES  lookups per cycle; 1, 2, 4 or 8
//  Revision    : 1.0  initial release
// ============================================================================
module des_sbox_scheduler #(
  parameter int LANES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  des_sbox_scheduler_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int       STEPS     = 8 / LANES;
  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  // S1..S8, each 4 rows x 16 columns of 4-bit entries, row 0 in the top
  // nibbles. Entry (row, col) lives at bits [255-4*(16*row+col) -: 4].
  localparam logic [255:0] SBOX_TBL [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FAB1E7608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Sg lookup on the raw 6-bit group: row = outer bits, column = inner four.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] g, input logic [5:0] x);
    logic [5:0] rc;
    rc = {x[5], x[0], x[4:1]};
    return SBOX_TBL[g][255 - 4*int'(rc) -: 4];
  endfunction

  state_e      state_q, state_d;
  logic [47:0] job_q, job_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic        out_valid_q, out_valid_d;

  logic        grant0, grant1;

  // Arbitration. The rst_n term keeps both readies low while reset is held,
  // since the FSM sits in IDLE during reset and a valid requester would
  // otherwise see a grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      grant0 = bus.in0_valid & (~bus.in1_valid | last_q);
      grant1 = bus.in1_valid & ~grant0;
    end
  end

  always_comb begin
    int grp;
    grp         = 0;
    state_d     = state_q;
    job_d       = job_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          job_d    = grant0 ? bus.in0_data : bus.in1_data;
          id_d     = grant1;
          last_d   = grant1;
          result_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // Groups cnt*LANES .. cnt*LANES+LANES-1 (0-based); group 0 is the
        // top six bits of the job and lands in the top nibble of the result.
        for (int l = 0; l < LANES; l++) begin
          grp = int'(cnt_q) * LANES + l;
          result_d[31 - 4*grp -: 4] = sbox_lookup(grp[2:0], job_q[47 - 6*grp -: 6]);
        end
        if (cnt_q == LAST_STEP) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      job_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in0_ready = grant0;
  assign bus.in1_ready = grant1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = result_q;
  assign bus.out_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_des_sbox_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_sbox_scheduler
//  Description : Scoreboard bench for des_sbox_scheduler. Main instance uses
//                LANES=1; three more instances (LANES=2,4,8) get an all-ones
//                latency job.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_des_sbox_scheduler;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int out_cnt  = 0;
  int lane_done = 0;

  // Standard DES S-box tables, row-major (row*16 + col).
  int SB [0:7][0:63] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // Reference substitution: DES bit 1 is the MSB of the 48-bit word.
  function automatic logic [31:0] ref_f(input logic [47:0] x);
    logic [31:0] r;
    int six, row, col;
    r = '0;
    for (int g = 0; g < 8; g++) begin
      six = int'((x >> (42 - 6*g)) & 48'h3F);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      r = r | (32'(SB[g][row*16 + col]) << (28 - 4*g));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- main DUT
  des_sbox_scheduler_if bus();
  des_sbox_scheduler #(.LANES(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic        id;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  bit   m_free = 1'b1;
  bit   m_last = 1'b1;
  bit   prev_ov = 1'b0;
  int   ncyc = 0;

  always @(negedge clk) begin
    bit e0, e1;
    ncyc++;
    if (!rst_n) begin
      check("reset_outputs",
            64'({bus.out_valid, bus.out_id, bus.out_data, bus.in0_ready, bus.in1_ready}), 64'd0);
      sbq.delete();
      m_free  = 1'b1;
      m_last  = 1'b1;
      prev_ov = 1'b0;
    end else begin
      e0 = m_free && bus.in0_valid && (!bus.in1_valid || m_last);
      e1 = m_free && bus.in1_valid && !e0;
      check("ready_arb", 64'({bus.in0_ready, bus.in1_ready}), 64'({e0, e1}));

      if (bus.in0_valid && bus.in0_ready) begin
        sbq.push_back('{id: 1'b0, data: ref_f(bus.in0_data), acc: ncyc});
        m_last = 1'b0; m_free = 1'b0; acc_cnt++;
      end else if (bus.in1_valid && bus.in1_ready) begin
        sbq.push_back('{id: 1'b1, data: ref_f(bus.in1_data), acc: ncyc});
        m_last = 1'b1; m_free = 1'b0; acc_cnt++;
      end

      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          check("out_unexpected", 64'(bus.out_valid), 64'd0);
        end else begin
          if (!prev_ov) check("latency", 64'(ncyc - sbq[0].acc), 64'd9);
          check("out_data", 64'(bus.out_data), 64'(sbq[0].data));
          check("out_id", 64'(bus.out_id), 64'(sbq[0].id));
          if (bus.out_ready) begin
            void'(sbq.pop_front());
            m_free = 1'b1;
            out_cnt++;
          end
        end
      end
      prev_ov = bus.out_valid && !bus.out_ready;
    end
  end

  // ---------------------------------------------------------------- lane instances
  for (genvar k = 1; k < 4; k++) begin : g_lane
    localparam int L = 1 << k;
    des_sbox_scheduler_if lbus();
    des_sbox_scheduler #(.LANES(L)) u_dut (.clk(clk), .rst_n(rst_n), .bus(lbus.slave));

    initial begin
      bit acc;
      int n;
      lbus.in0_valid = 1'b0; lbus.in0_data = '0;
      lbus.in1_valid = 1'b0; lbus.in1_data = '0;
      lbus.out_ready = 1'b1;
      @(posedge rst_n);
      @(posedge clk); #1;
      lbus.in1_valid = 1'b1;
      lbus.in1_data  = 48'hFFFF_FFFF_FFFF;
      acc = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (lbus.in1_ready) begin acc = 1'b1; break; end
      end
      check("lane_accept", 64'(acc), 64'd1);
      @(posedge clk); #1;
      lbus.in1_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        n++;
        if (lbus.out_valid) break;
      end
      check("lane_latency", 64'(n), 64'(8 / L + 1));
      check("lane_data", 64'(lbus.out_data), 64'(ref_f(48'hFFFF_FFFF_FFFF)));
      check("lane_id", 64'(lbus.out_id), 64'd1);
      lane_done++;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic wait_acc(input int target);
    int k = 0;
    while (acc_cnt < target && k < 60) begin tick(); k++; end
    check("accept_timeout", 64'(acc_cnt >= target), 64'd1);
  endtask

  task automatic drain();
    int k = 0;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
    while ((sbq.size() != 0 || bus.out_valid) && k < 40) begin tick(); k++; end
    check("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int target;
    rst_n = 1'b0;
    bus.in0_valid = 1'b0; bus.in0_data = '0;
    bus.in1_valid = 1'b0; bus.in1_data = '0;
    bus.out_ready = 1'b1;
    #1;
    check("init_out_valid", 64'(bus.out_valid), 64'd0);
    check("init_out_data", 64'(bus.out_data), 64'd0);
    check("init_ready", 64'({bus.in0_ready, bus.in1_ready}), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Zero input on requester 0
    bus.in0_valid = 1'b1; bus.in0_data = '0;
    wait_acc(acc_cnt + 1);
    bus.in0_valid = 1'b0;
    drain();

    // All-ones input on requester 1
    bus.in1_valid = 1'b1; bus.in1_data = 48'hFFFF_FFFF_FFFF;
    wait_acc(acc_cnt + 1);
    bus.in1_valid = 1'b0;
    drain();

    // Data change after acceptance
    bus.in0_valid = 1'b1; bus.in0_data = rnd48();
    wait_acc(acc_cnt + 1);
    bus.in0_valid = 1'b0;
    bus.in0_data  = ~bus.in0_data;
    tick();
    bus.in0_data  = rnd48();
    drain();

    // Contention from reset
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = '0;
    bus.in1_valid = 1'b1; bus.in1_data = 48'hFFFF_FFFF_FFFF;
    target = out_cnt + 6;
    k = 0;
    while (out_cnt < target && k < 120) begin tick(); k++; end
    check("contention_timeout", 64'(out_cnt >= target), 64'd1);
    drain();

    // Backpressure in DONE with requester 1 re-presenting
    bus.out_ready = 1'b0;
    bus.in1_valid = 1'b1; bus.in1_data = rnd48();
    wait_acc(acc_cnt + 1);
    bus.in1_data = rnd48();
    k = 0;
    while (!bus.out_valid && k < 20) begin tick(); k++; end
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    repeat (20) tick();
    target = acc_cnt + 1;
    bus.out_ready = 1'b1;
    k = 0;
    while (acc_cnt < target && k < 10) begin tick(); k++; end
    check("bp_reaccept_cycles", 64'(k), 64'd2);
    bus.in1_valid = 1'b0;
    drain();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.in0_valid = 1'($urandom_range(0, 1));
      bus.in1_valid = 1'($urandom_range(0, 1));
      bus.in0_data  = rnd48();
      bus.in1_data  = rnd48();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset in the middle of RUN
    bus.in1_valid = 1'b1; bus.in1_data = rnd48();
    wait_acc(acc_cnt + 1);
    bus.in1_valid = 1'b0;
    repeat (3) tick();
    bus.in0_valid = 1'b1; bus.in0_data = rnd48();
    bus.in1_valid = 1'b1; bus.in1_data = rnd48();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrun_out_data", 64'(bus.out_data), 64'd0);
    check("midrun_out_id", 64'(bus.out_id), 64'd0);
    check("midrun_ready", 64'({bus.in0_ready, bus.in1_ready}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    target = out_cnt + 2;
    k = 0;
    while (out_cnt < target && k < 60) begin tick(); k++; end
    check("post_reset_timeout", 64'(out_cnt >= target), 64'd1);
    drain();

    k = 0;
    while (lane_done < 3 && k < 100) begin tick(); k++; end
    check("lane_instances_done", 64'(lane_done), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/des_sbox_scheduler.md
# des_sbox_scheduler

Shares one bank of DES S-box lookup logic (the existing S1..S8 modules) between two requesters, such as an encrypt round core and a decrypt round core. It sequences the eight 6-bit lookups of a 48-bit round-function input over several cycles, then returns the 32-bit substituted word. A round-robin arbiter picks which requester is served. Valid/ready handshakes are used on both sides.

## Interface
- LANES, default 1: lookups per cycle.
  - Legal values are 1, 2, 4 and 8.
  - Sets the job length to 8/LANES RUN cycles.
- clk  input  1  Clock, rising edge.
- rst_n  input  1  Asynchronous active-low reset.
- in0_valid  input  1  Requester 0 has a job.
- in0_data  input  48  Requester 0 input, bits [48:1], DES bit 1 = MSB.
- in0_ready  output  1  Requester 0 job accepted this cycle.
- in1_valid  input  1  Requester 1 has a job.
- in1_data  input  48  Requester 1 input, bits [48:1], DES bit 1 = MSB.
- in1_ready  output  1  Requester 1 job accepted this cycle.
- out_valid  output  1  Result available.
- out_data  output  32  Substituted word, bits [32:1].
- out_id  output  1  Requester that owns the result.
- out_ready  input  1  Consumer accepts the result.

## Operation
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset values:
  - FSM is in IDLE.
  - in0_ready = in1_ready = 0.
  - out_valid = 0, out_data = 0, out_id = 0.
  - Group counter = 0.
  - Last-served pointer = 1, so requester 0 wins the first tie.
- Group mapping:
  - Group g (1..8) is in_data[48-6(g-1) : 43-6(g-1)] and feeds Sg.
  - The Sg result goes to out_data[32-4(g-1) : 29-4(g-1)].
  - The raw 6-bit group value is passed unchanged as the S-module index; row/column decoding happens inside Sg.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Arbitration is combinational, and in*_ready is asserted only toward the winner.
  - If only one requester is valid, it wins.
  - If both are valid, the one not in the last-served pointer wins.
  - On acceptance (inX_valid & inX_ready):
    - Latch inX_data into the 48-bit job register.
    - Record X into the id register and the last-served pointer.
    - Clear the result register and counter.
    - Go to RUN.
- RUN:
  - Each cycle evaluates groups counter·LANES+1 .. counter·LANES+LANES, using a mux from the job register to the S-module inputs.
  - Results are written into their nibbles of the result register; the counter increments.
  - When the last group is written (counter = 8/LANES − 1), go to DONE.
- DONE:
  - out_valid = 1; out_data and out_id are stable.
  - On out_ready, go to IDLE and drop out_valid next cycle.
- Both in*_ready are 0 outside IDLE. A requester may hold valid indefinitely without losing its request.
- Changes to in*_data after acceptance do not affect the job in flight.

## Timing
- Acceptance edge is E0.
- out_valid rises after edge E(8/LANES):
  - LANES=1: 8 cycles.
  - LANES=8: 1 cycle.
- out_valid deasserts after the edge where out_valid & out_ready.
- The earliest next acceptance is the following cycle (IDLE is ≥1 cycle).
- Throughput: one job per 8/LANES + 2 cycles under back-to-back traffic with out_ready held high.
- Backpressure: out_ready low holds DONE indefinitely, with out_data/out_id stable and no acceptance.
- Simultaneous requests: exactly one of in0_ready/in1_ready is high, never both. Under continuous contention the requesters alternate.
- Reset mid-RUN or mid-DONE:
  - Immediately (asynchronously) returns all outputs to their reset values.
  - The job is dropped with no partial result.
  - The requester must re-present.

## Test plan
- Zero input: reset, in0_valid with in0_data = 0, LANES=1.
  - in0_ready goes high for one cycle.
  - After 8 cycles: out_valid=1, out_data=0xEFA72C4D, out_id=0.
- All-ones input: in1_data = 48'hFFFFFFFFFFFF.
  - Expect out_data=0xD9CE3DCB, out_id=1.
  - Repeat with LANES=2, 4, 8; latency must be 4, 2, 1 cycles.
- Contention: both valid continuously from reset, data 0 and all-ones respectively, out_ready=1.
  - Grants alternate 0,1,0,1.
  - out_id sequence is 0,1,0,1 with matching results.
  - Never both ready.
- Backpressure: out_ready=0 for 20 cycles in DONE.
  - out_valid/out_data stable.
  - No in*_ready while in1_valid is held.
  - Raise out_ready: accepted next IDLE cycle.
- Data change after accept: modify in0_data one cycle after acceptance.
  - The result still matches the originally latched value.
- Reset mid-RUN: assert rst_n=0 at RUN cycle 4.
  - All outputs 0 immediately.
  - After release, a new job completes correctly, and requester 0 wins the tie.
